// File: rtl/axis_pkt_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_sink_pkg
// Brief    : Shared widths, LFSR constants and FSM encoding for axis_pkt_sink.
// Revision : 1.0
// ============================================================================
package axis_pkt_sink_pkg;

    localparam int          C_DATA_WIDTH  = 256;
    localparam int          C_KEEP_WIDTH  = C_DATA_WIDTH / 8;
    localparam int          C_TUSER_WIDTH = 128;
    localparam logic [15:0] C_LFSR_RESET  = 16'hACE1;
    // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10.
    localparam logic [15:0] C_LFSR_TAPS   = 16'hB400;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } pkt_state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_bp_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : axis_bp_lfsr
// Brief    : Free-running LFSR producing a registered pseudo-random ready bit.
// Revision : 1.0
// ============================================================================
module axis_bp_lfsr
    import axis_pkt_sink_pkg::*;
#(
    parameter logic [15:0] LFSR_RESET = C_LFSR_RESET
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_bp_en,
    input  logic [15:0] i_seed,
    input  logic        i_clear,
    output logic        o_ready
);

    logic [15:0] r_lfsr;
    logic        r_started;
    logic        r_ready;
    logic        w_fb;

    assign w_fb    = ^(r_lfsr & C_LFSR_TAPS);
    assign o_ready = r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_RESET;
        end else if (i_clear) begin
            // An all-zero state would lock the LFSR, so a zero seed falls back.
            r_lfsr <= (i_seed == 16'h0000) ? LFSR_RESET : i_seed;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    // Ready is held low for the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started <= 1'b0;
            r_ready   <= 1'b0;
        end else if (!r_started) begin
            r_started <= 1'b1;
        end else begin
            r_ready   <= i_bp_en ? r_lfsr[0] : 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_pkt_sink.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_sink
// Brief    : AXI-Stream sink with packet statistics and protocol checking.
// Revision : 1.0
// ============================================================================
module axis_pkt_sink
    import axis_pkt_sink_pkg::*;
#(
    parameter int          C_S_AXIS_DATA_WIDTH  = C_DATA_WIDTH,
    parameter int          C_S_AXIS_TUSER_WIDTH = C_TUSER_WIDTH,
    parameter logic [15:0] LFSR_RESET           = C_LFSR_RESET
) (
    input  logic                              axis_aclk,
    input  logic                              axis_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic                              bp_en,
    input  logic [15:0]                       bp_seed,
    input  logic                              clear,
    output logic [31:0]                       pkt_count,
    output logic [31:0]                       beat_count,
    output logic [47:0]                       byte_count,
    output logic [15:0]                       last_len,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   last_tuser,
    output logic                              err_keep,
    output logic                              err_stable,
    output logic [15:0]                       err_count
);

    localparam int                  C_KEEP_W   = C_S_AXIS_DATA_WIDTH / 8;
    localparam logic [C_KEEP_W-1:0] C_KEEP_ONE = 1;

    function automatic logic [15:0] f_popcount(input logic [C_KEEP_W-1:0] k);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < C_KEEP_W; i++) n = n + {15'd0, k[i]};
        return n;
    endfunction

    pkt_state_t                        r_state, w_state_nxt;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   r_held_tuser;
    logic [15:0]                       r_run_len;
    logic                              r_stalled;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    r_prev_data;
    logic [C_KEEP_W-1:0]               r_prev_keep;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   r_prev_user;
    logic                              r_prev_last;

    logic        w_hs;
    logic        w_first;
    logic [15:0] w_beat_bytes;
    logic [15:0] w_run_sum;
    logic        w_keep_contig;
    logic        w_keep_viol;
    logic        w_stable_viol;

    axis_bp_lfsr #(
        .LFSR_RESET (LFSR_RESET)
    ) u_bp_lfsr (
        .clk     (axis_aclk),
        .rst_n   (axis_resetn),
        .i_bp_en (bp_en),
        .i_seed  (bp_seed),
        .i_clear (clear),
        .o_ready (s_axis_tready)
    );

    assign w_hs          = s_axis_tvalid & s_axis_tready;
    assign w_first       = (r_state == ST_IDLE);
    assign w_beat_bytes  = f_popcount(s_axis_tkeep);
    assign w_run_sum     = sat_add16(r_run_len, w_beat_bytes);
    // A last-beat keep must be contiguous from bit 0 (2^n-1, n >= 1).
    assign w_keep_contig = ((s_axis_tkeep & (s_axis_tkeep + C_KEEP_ONE)) == '0) &&
                           (s_axis_tkeep != '0);
    assign w_keep_viol   = w_hs & (s_axis_tlast ? !w_keep_contig : !(&s_axis_tkeep));
    assign w_stable_viol = r_stalled & (!s_axis_tvalid ||
                                        (s_axis_tdata != r_prev_data) ||
                                        (s_axis_tkeep != r_prev_keep) ||
                                        (s_axis_tuser != r_prev_user) ||
                                        (s_axis_tlast != r_prev_last));

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) r_state <= ST_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear)     w_state_nxt = ST_IDLE;
        else if (w_hs) w_state_nxt = s_axis_tlast ? ST_IDLE : ST_IN_PKT;
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_stalled   <= 1'b0;
            r_prev_data <= '0;
            r_prev_keep <= '0;
            r_prev_user <= '0;
            r_prev_last <= 1'b0;
        end else begin
            r_stalled   <= s_axis_tvalid & ~s_axis_tready;
            r_prev_data <= s_axis_tdata;
            r_prev_keep <= s_axis_tkeep;
            r_prev_user <= s_axis_tuser;
            r_prev_last <= s_axis_tlast;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            pkt_count    <= '0;
            beat_count   <= '0;
            byte_count   <= '0;
            last_len     <= '0;
            last_tuser   <= '0;
            err_keep     <= 1'b0;
            err_stable   <= 1'b0;
            err_count    <= '0;
            r_held_tuser <= '0;
            r_run_len    <= '0;
        end else if (clear) begin
            pkt_count    <= '0;
            beat_count   <= '0;
            byte_count   <= '0;
            last_len     <= '0;
            last_tuser   <= '0;
            err_keep     <= 1'b0;
            err_stable   <= 1'b0;
            err_count    <= '0;
            r_held_tuser <= '0;
            r_run_len    <= '0;
        end else begin
            if (w_hs) begin
                beat_count <= beat_count + 32'd1;
                byte_count <= byte_count + {32'd0, w_beat_bytes};
                if (w_first) begin
                    r_held_tuser <= s_axis_tuser;
                    r_run_len    <= w_beat_bytes;
                end else begin
                    r_run_len    <= w_run_sum;
                end
                if (s_axis_tlast) begin
                    pkt_count  <= pkt_count + 32'd1;
                    last_len   <= w_first ? w_beat_bytes : w_run_sum;
                    last_tuser <= w_first ? s_axis_tuser : r_held_tuser;
                end
            end
            if (w_keep_viol)   err_keep   <= 1'b1;
            if (w_stable_viol) err_stable <= 1'b1;
            if ((w_keep_viol || w_stable_viol) && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pkt_sink
// Brief    : Directed self-checking bench for axis_pkt_sink.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_axis_pkt_sink;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] tdata = '0;
    logic [31:0]  tkeep = '0;
    logic [127:0] tuser = '0;
    logic         tvalid = 1'b0;
    logic         tready;
    logic         tlast = 1'b0;
    logic         bp_en = 1'b0;
    logic [15:0]  bp_seed = 16'h0000;
    logic         clear = 1'b0;
    logic [31:0]  pkt_count, beat_count;
    logic [47:0]  byte_count;
    logic [15:0]  last_len, err_count;
    logic [127:0] last_tuser;
    logic         err_keep, err_stable;

    int checks = 0;
    int errors = 0;
    int stall_cycles = 0;

    always #5 clk = ~clk;

    axis_pkt_sink dut (
        .axis_aclk     (clk),
        .axis_resetn   (rst_n),
        .s_axis_tdata  (tdata),
        .s_axis_tkeep  (tkeep),
        .s_axis_tuser  (tuser),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .bp_en         (bp_en),
        .bp_seed       (bp_seed),
        .clear         (clear),
        .pkt_count     (pkt_count),
        .beat_count    (beat_count),
        .byte_count    (byte_count),
        .last_len      (last_len),
        .last_tuser    (last_tuser),
        .err_keep      (err_keep),
        .err_stable    (err_stable),
        .err_count     (err_count)
    );

    // Called at a negedge; holds the beat stable until accepted, returns at the next negedge.
    task automatic send_beat(input logic [255:0] d, input logic [31:0] k,
                             input logic [127:0] u, input logic l);
        int n;
        tdata = d; tkeep = k; tuser = u; tlast = l; tvalid = 1'b1;
        n = 0;
        while (tready !== 1'b1 && n < 200) begin
            stall_cycles++;
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL send_beat_timeout: tready=%b still low after %0d cycles, required 1", tready, n);
        end
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", tready); end
        checks++; if (pkt_count !== 32'd0 || beat_count !== 32'd0 || byte_count !== 48'd0) begin errors++;
            $display("FAIL reset_counts: got pkt=%0d beat=%0d byte=%0d expected 0", pkt_count, beat_count, byte_count); end
        checks++; if (err_keep !== 1'b0 || err_stable !== 1'b0 || err_count !== 16'd0 || last_len !== 16'd0 || last_tuser !== '0) begin errors++;
            $display("FAIL reset_errs: got keep=%b stable=%b cnt=%0d len=%0d expected zeros", err_keep, err_stable, err_count, last_len); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL ready_first_edge: got %b expected 0", tready); end
        @(negedge clk);
        checks++; if (tready !== 1'b1) begin errors++; $display("FAIL ready_second_edge: got %b expected 1", tready); end
    endtask

    task automatic test_three_beat();
        send_beat({8{32'h11111111}}, 32'hFFFFFFFF, 128'h1234, 1'b0);
        send_beat({8{32'h22222222}}, 32'hFFFFFFFF, 128'h5555, 1'b0);
        send_beat({8{32'h33333333}}, 32'h0000FFFF, 128'h6666, 1'b1);
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL three_pkt: got %0d expected 1", pkt_count); end
        checks++; if (beat_count !== 32'd3) begin errors++; $display("FAIL three_beat: got %0d expected 3", beat_count); end
        checks++; if (byte_count !== 48'd80) begin errors++; $display("FAIL three_bytes: got %0d expected 80", byte_count); end
        checks++; if (last_len !== 16'd80) begin errors++; $display("FAIL three_len: got %0d expected 80", last_len); end
        checks++; if (last_tuser !== 128'h1234) begin errors++; $display("FAIL three_tuser: got %h expected 1234", last_tuser); end
        checks++; if (err_keep !== 1'b0 || err_stable !== 1'b0 || err_count !== 16'd0) begin errors++;
            $display("FAIL three_errs: got keep=%b stable=%b cnt=%0d expected 0", err_keep, err_stable, err_count); end
    endtask

    task automatic test_single_beat();
        send_beat({8{32'hA5A5A5A5}}, 32'h000000FF, 128'hBEEF, 1'b1);
        checks++; if (pkt_count !== 32'd2 || beat_count !== 32'd4 || byte_count !== 48'd88) begin errors++;
            $display("FAIL single_counts: got pkt=%0d beat=%0d byte=%0d expected 2/4/88", pkt_count, beat_count, byte_count); end
        checks++; if (last_len !== 16'd8) begin errors++; $display("FAIL single_len: got %0d expected 8", last_len); end
        checks++; if (last_tuser !== 128'hBEEF) begin errors++; $display("FAIL single_tuser: got %h expected beef", last_tuser); end
    endtask

    task automatic test_keep_errors();
        do_clear();
        send_beat({8{32'h01020304}}, 32'h0000FFFF, 128'h1, 1'b0);
        checks++; if (err_keep !== 1'b1 || err_count !== 16'd1) begin errors++;
            $display("FAIL keep_nonlast: got keep=%b cnt=%0d expected 1/1", err_keep, err_count); end
        send_beat({8{32'h05060708}}, 32'h000000F0, 128'h2, 1'b1);
        checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL keep_last: got cnt=%0d expected 2", err_count); end
        checks++; if (pkt_count !== 32'd1 || last_len !== 16'd20) begin errors++;
            $display("FAIL keep_pkt: got pkt=%0d len=%0d expected 1/20", pkt_count, last_len); end
        checks++; if (err_stable !== 1'b0) begin errors++; $display("FAIL keep_stable: got %b expected 0", err_stable); end
    endtask

    // Default tkeep is 32 bits, so each 64-byte packet is sent as two full beats.
    task automatic test_backpressure();
        bp_en = 1'b1; bp_seed = 16'h0001;
        do_clear();
        stall_cycles = 0;
        for (int p = 0; p < 100; p++) begin
            send_beat({8{p[31:0]}}, 32'hFFFFFFFF, {96'd0, p[31:0]}, 1'b0);
            send_beat({8{~p[31:0]}}, 32'hFFFFFFFF, 128'hF00D, 1'b1);
        end
        checks++; if (pkt_count !== 32'd100) begin errors++; $display("FAIL bp_pkt: got %0d expected 100", pkt_count); end
        checks++; if (beat_count !== 32'd200 || byte_count !== 48'd6400) begin errors++;
            $display("FAIL bp_counts: got beat=%0d byte=%0d expected 200/6400", beat_count, byte_count); end
        checks++; if (last_len !== 16'd64 || last_tuser !== 128'd99) begin errors++;
            $display("FAIL bp_last: got len=%0d tuser=%h expected 64/63", last_len, last_tuser); end
        checks++; if (err_stable !== 1'b0 || err_count !== 16'd0) begin errors++;
            $display("FAIL bp_errs: got stable=%b cnt=%0d expected 0/0", err_stable, err_count); end
        checks++; if (stall_cycles == 0) begin errors++; $display("FAIL bp_active: got %0d stall cycles expected >0", stall_cycles); end
    endtask

    task automatic test_stable_error();
        int n;
        do_clear();
        n = 0;
        while (tready !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL stable_find_stall: got tready=%b expected 0", tready); end
        tdata = {8{32'hCAFEF00D}}; tkeep = 32'hFFFFFFFF; tuser = 128'h7; tlast = 1'b1; tvalid = 1'b1;
        @(negedge clk);
        tdata = {8{32'hDEADBEEF}};
        @(negedge clk);
        checks++; if (err_stable !== 1'b1) begin errors++; $display("FAIL stable_set: got %b expected 1", err_stable); end
        tvalid = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (err_stable !== 1'b1 || err_keep !== 1'b0) begin errors++;
            $display("FAIL stable_sticky: got stable=%b keep=%b expected 1/0", err_stable, err_keep); end
        do_clear();
        checks++; if (err_stable !== 1'b0 || err_count !== 16'd0) begin errors++;
            $display("FAIL stable_clear: got stable=%b cnt=%0d expected 0/0", err_stable, err_count); end
        bp_en = 1'b0;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_clear_last();
        do_clear();
        send_beat({8{32'h1}}, 32'hFFFFFFFF, 128'hAA, 1'b0);
        send_beat({8{32'h2}}, 32'hFFFFFFFF, 128'hBB, 1'b0);
        clear = 1'b1;
        send_beat({8{32'h3}}, 32'h000000FF, 128'hCC, 1'b1);
        clear = 1'b0;
        checks++; if (pkt_count !== 32'd0 || beat_count !== 32'd0 || byte_count !== 48'd0) begin errors++;
            $display("FAIL clear_counts: got pkt=%0d beat=%0d byte=%0d expected 0", pkt_count, beat_count, byte_count); end
        checks++; if (last_len !== 16'd0 || last_tuser !== '0) begin errors++;
            $display("FAIL clear_last: got len=%0d tuser=%h expected 0", last_len, last_tuser); end
        send_beat({8{32'h4}}, 32'h0000000F, 128'hDD, 1'b1);
        checks++; if (pkt_count !== 32'd1 || last_len !== 16'd4 || last_tuser !== 128'hDD) begin errors++;
            $display("FAIL clear_after: got pkt=%0d len=%0d tuser=%h expected 1/4/dd", pkt_count, last_len, last_tuser); end
    endtask

    task automatic test_reset_mid();
        send_beat({8{32'h9}}, 32'hFFFFFFFF, 128'h99, 1'b0);
        send_beat({8{32'h8}}, 32'hFFFFFFFF, 128'h88, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (tready !== 1'b0 || pkt_count !== 32'd0 || beat_count !== 32'd0) begin errors++;
            $display("FAIL midrst_async: got ready=%b pkt=%0d beat=%0d expected 0", tready, pkt_count, beat_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        send_beat({8{32'h7}}, 32'h0000000F, 128'h77, 1'b1);
        checks++; if (pkt_count !== 32'd1 || last_len !== 16'd4) begin errors++;
            $display("FAIL midrst_pkt: got pkt=%0d len=%0d expected 1/4", pkt_count, last_len); end
        checks++; if (beat_count !== 32'd1 || last_tuser !== 128'h77) begin errors++;
            $display("FAIL midrst_beat: got beat=%0d tuser=%h expected 1/77", beat_count, last_tuser); end
    endtask

    initial begin
        test_reset();
        test_three_beat();
        test_single_beat();
        test_keep_errors();
        test_backpressure();
        test_stable_error();
        test_clear_last();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
